// File: rtl/cmp_sequencer.sv
// cmp_sequencer: issues EQ/GT/LT to the compare unit for one operand pair and
// returns a checked one-hot relation on a valid/ready response port.
`default_nettype none

module cmp_sequencer #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      REQ_VALID,
  output logic                      REQ_READY,
  input  logic [IN_DATA_WIDTH-1:0]  REQ_A,
  input  logic [IN_DATA_WIDTH-1:0]  REQ_B,
  output logic [IN_DATA_WIDTH-1:0]  CMP_A,
  output logic [IN_DATA_WIDTH-1:0]  CMP_B,
  output logic                      CMP_Enable,
  output logic [1:0]                CMP_FUN_SEL,
  input  logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
  input  logic                      CMP_Flag,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic                      RSP_EQ,
  output logic                      RSP_GT,
  output logic                      RSP_LT,
  output logic                      RSP_ERR
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [1:0]               coll_q, coll_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [2:0]               dec_q, dec_d;
  logic                     sticky_q, sticky_d;
  logic [IN_DATA_WIDTH-1:0] cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
  logic                     cmp_en_q, cmp_en_d;
  logic [1:0]               fun_sel_q, fun_sel_d;
  logic                     req_ready_q, req_ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_eq_q, rsp_eq_d, rsp_gt_q, rsp_gt_d, rsp_lt_q, rsp_lt_d;
  logic                     rsp_err_q, rsp_err_d;

  // Slot n encodes "true" as the value n+1; zero means false, anything else is bad.
  logic [OUT_DATA_WIDTH-1:0] w_exp_code;
  logic                      w_code_bit;
  logic                      w_code_ok;

  assign w_exp_code = OUT_DATA_WIDTH'(coll_q) + OUT_DATA_WIDTH'(1);
  assign w_code_bit = (CMP_OUT == w_exp_code);
  assign w_code_ok  = w_code_bit || (CMP_OUT == '0);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    coll_d      = coll_q;
    tmo_d       = tmo_q;
    dec_d       = dec_q;
    sticky_d    = sticky_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    cmp_en_d    = cmp_en_q;
    fun_sel_d   = fun_sel_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_eq_d    = rsp_eq_q;
    rsp_gt_d    = rsp_gt_q;
    rsp_lt_d    = rsp_lt_q;
    rsp_err_d   = rsp_err_q;

    if ((state_q == ISSUE || state_q == DRAIN) && CMP_Flag && coll_q != 2'd3) begin
      dec_d[coll_q] = w_code_bit;
      if (!w_code_ok) sticky_d = 1'b1;
      coll_d = coll_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (REQ_VALID && req_ready_q) begin
          cmp_a_d     = REQ_A;
          cmp_b_d     = REQ_B;
          cmp_en_d    = 1'b1;
          fun_sel_d   = 2'b01;
          idx_d       = 2'd0;
          req_ready_d = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        case (idx_q)
          2'd0: begin
            fun_sel_d = 2'b10;
            idx_d     = 2'd1;
          end
          2'd1: begin
            fun_sel_d = 2'b11;
            idx_d     = 2'd2;
          end
          default: begin
            cmp_en_d  = 1'b0;
            fun_sel_d = 2'b00;
            tmo_d     = '0;
            state_d   = DRAIN;
          end
        endcase
      end
      DRAIN: begin
        if (coll_q == 2'd3) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_eq_d    = dec_q[0];
          rsp_gt_d    = dec_q[1];
          rsp_lt_d    = dec_q[2];
          rsp_err_d   = sticky_q || !$onehot(dec_q);
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_eq_d    = 1'b0;
          rsp_gt_d    = 1'b0;
          rsp_lt_d    = 1'b0;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RESP: begin
        if (RSP_READY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_eq_d    = 1'b0;
          rsp_gt_d    = 1'b0;
          rsp_lt_d    = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          idx_d       = 2'd0;
          coll_d      = 2'd0;
          tmo_d       = '0;
          dec_d       = 3'b000;
          sticky_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      coll_q      <= 2'd0;
      tmo_q       <= '0;
      dec_q       <= 3'b000;
      sticky_q    <= 1'b0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      cmp_en_q    <= 1'b0;
      fun_sel_q   <= 2'b00;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_eq_q    <= 1'b0;
      rsp_gt_q    <= 1'b0;
      rsp_lt_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      coll_q      <= coll_d;
      tmo_q       <= tmo_d;
      dec_q       <= dec_d;
      sticky_q    <= sticky_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      cmp_en_q    <= cmp_en_d;
      fun_sel_q   <= fun_sel_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_eq_q    <= rsp_eq_d;
      rsp_gt_q    <= rsp_gt_d;
      rsp_lt_q    <= rsp_lt_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign REQ_READY   = req_ready_q;
  assign CMP_A       = cmp_a_q;
  assign CMP_B       = cmp_b_q;
  assign CMP_Enable  = cmp_en_q;
  assign CMP_FUN_SEL = fun_sel_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_EQ      = rsp_eq_q;
  assign RSP_GT      = rsp_gt_q;
  assign RSP_LT      = rsp_lt_q;
  assign RSP_ERR     = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cmp_sequencer.sv
// tb_cmp_sequencer: drives cmp_sequencer against a behavioural compare unit and
// checks each response against relations computed directly from the operands.
`default_nettype none

module tb_cmp_sequencer;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [15:0] REQ_A = '0, REQ_B = '0;
  logic [15:0] CMP_A, CMP_B;
  logic        CMP_Enable;
  logic [1:0]  CMP_FUN_SEL;
  logic [15:0] CMP_OUT = '0;
  logic        CMP_Flag = 1'b0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b1;
  logic        RSP_EQ, RSP_GT, RSP_LT, RSP_ERR;

  int errors = 0;
  int checks = 0;

  // compare-unit model behaviour: 0 normal, 1 bad code in one slot, 2 all zero, 3 no flag
  int          cu_mode = 0;
  int          cu_bad_slot = 0;
  logic [15:0] cu_bad_val = '0;

  cmp_sequencer #(
    .IN_DATA_WIDTH (16),
    .OUT_DATA_WIDTH(16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_A      (REQ_A),
    .REQ_B      (REQ_B),
    .CMP_A      (CMP_A),
    .CMP_B      (CMP_B),
    .CMP_Enable (CMP_Enable),
    .CMP_FUN_SEL(CMP_FUN_SEL),
    .CMP_OUT    (CMP_OUT),
    .CMP_Flag   (CMP_Flag),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_EQ     (RSP_EQ),
    .RSP_GT     (RSP_GT),
    .RSP_LT     (RSP_LT),
    .RSP_ERR    (RSP_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] cu_code(input logic [1:0] sel, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    case (sel)
      2'b01:   r = (a == b) ? 16'd1 : 16'd0;
      2'b10:   r = (a > b)  ? 16'd2 : 16'd0;
      2'b11:   r = (a < b)  ? 16'd3 : 16'd0;
      default: r = 16'd0;
    endcase
    if (cu_mode == 2) r = 16'd0;
    if (cu_mode == 1 && int'(sel) == cu_bad_slot + 1) r = cu_bad_val;
    return r;
  endfunction

  always @(posedge CLK) begin
    if (CMP_Enable && cu_mode != 3) begin
      CMP_Flag <= 1'b1;
      CMP_OUT  <= cu_code(CMP_FUN_SEL, CMP_A, CMP_B);
    end else begin
      CMP_Flag <= 1'b0;
      CMP_OUT  <= '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int mode,
                         input int bad_slot, input logic [15:0] bad_val, input int hold);
    logic e_eq, e_gt, e_lt, e_err;
    int   e_lat, lat, w;
    e_eq = (a == b); e_gt = (a > b); e_lt = (a < b); e_err = 1'b0; e_lat = 5;
    cu_mode = mode; cu_bad_slot = bad_slot; cu_bad_val = bad_val;
    if (mode == 1) begin
      e_err = 1'b1;
      if (bad_slot == 0) e_eq = 1'b0;
      if (bad_slot == 1) e_gt = 1'b0;
      if (bad_slot == 2) e_lt = 1'b0;
    end else if (mode >= 2) begin
      e_err = 1'b1; e_eq = 1'b0; e_gt = 1'b0; e_lt = 1'b0;
      if (mode == 3) e_lat = 3 + TO;
    end

    w = 0;
    while (!REQ_READY && w < 10) begin tick(); w++; end
    check("req_ready_idle", REQ_READY, 1);
    REQ_A = a; REQ_B = b; REQ_VALID = 1'b1; RSP_READY = (hold == 0);
    tick();
    REQ_VALID = 1'b0;
    check("req_ready_busy", REQ_READY, 0);
    check("cmp_a", CMP_A, a);
    check("cmp_b", CMP_B, b);
    check("issue0", {CMP_Enable, CMP_FUN_SEL}, 3'b101);
    tick();
    check("issue1", {CMP_Enable, CMP_FUN_SEL}, 3'b110);
    tick();
    check("issue2", {CMP_Enable, CMP_FUN_SEL}, 3'b111);
    tick();
    check("drain_idle_bus", {CMP_Enable, CMP_FUN_SEL}, 3'b000);
    lat = 3;
    while (!RSP_VALID && lat < 40) begin tick(); lat++; end
    check("latency", lat, e_lat);
    check("rsp_fields", {RSP_EQ, RSP_GT, RSP_LT, RSP_ERR}, {e_eq, e_gt, e_lt, e_err});
    check("req_ready_resp", REQ_READY, 0);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("rsp_stable", {RSP_VALID, RSP_EQ, RSP_GT, RSP_LT, RSP_ERR},
            {1'b1, e_eq, e_gt, e_lt, e_err});
    end
    RSP_READY = 1'b1;
    tick();
    check("rsp_done", {RSP_VALID, REQ_READY}, 2'b01);
  endtask

  initial begin
    logic [15:0] a, b, v;
    int          mode, slot, seen;

    repeat (3) tick();
    check("reset_outs", {REQ_READY, RSP_VALID, CMP_Enable, CMP_FUN_SEL, RSP_ERR}, 6'b100000);
    RST = 1'b0;
    tick();

    run_txn(16'h0005, 16'h0005, 0, 0, 16'h0, 0);
    run_txn(16'h0010, 16'h0003, 0, 0, 16'h0, 0);
    run_txn(16'h0003, 16'h0010, 0, 0, 16'h0, 0);
    run_txn(16'h0005, 16'h0005, 1, 0, 16'h0002, 0);
    run_txn(16'h0008, 16'h0001, 2, 0, 16'h0, 0);
    run_txn(16'h0008, 16'h0001, 3, 0, 16'h0, 0);
    run_txn(16'h0001, 16'h0008, 0, 0, 16'h0, 4);

    // asynchronous reset during the GT issue cycle
    cu_mode = 0;
    REQ_A = 16'h0020; REQ_B = 16'h0001; REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    tick();
    check("rst_pre_gt", {CMP_Enable, CMP_FUN_SEL}, 3'b110);
    #2 RST = 1'b1;
    #1;
    check("rst_async", {CMP_Enable, REQ_READY, RSP_VALID}, 3'b010);
    tick();
    RST = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (RSP_VALID) seen = 1;
    end
    check("rst_no_rsp", seen, 0);
    run_txn(16'd7, 16'd9, 0, 0, 16'h0, 0);

    for (int n = 0; n < 30; n++) begin
      a = 16'($urandom_range(0, 15));
      b = ($urandom_range(0, 2) == 0) ? a : 16'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = 16'($urandom);
      mode = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      slot = int'($urandom_range(0, 2));
      v = 16'($urandom);
      if (v == 16'h0 || v == 16'(slot + 1)) v = 16'h8000;
      run_txn(a, b, mode, slot, v, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
